jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
- JTAG master-side scan controller.
- Accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready interface.
- Generates TCK, TMS and TDI to walk the 16-state TAP controller through each scan, samples TDO, and returns the captured bits.
- Keeps an internal model of the TAP state using the team's standard 4-bit TAP encoding, and exports it for debug.

Parameters:
- MAX_LEN, 64, maximum scan length in bits; width of cmd_data and rsp_data.
- TCK_HALF, 2, clock cycles per TCK half-period; must be at least 1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (treated as no-op)
- cmd_len  in  $clog2(MAX_LEN+1)  number of bits to shift
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  MAX_LEN  captured TDO bits; bit i is the i-th shifted bit
- io_tck  out  1  JTAG TCK
- io_tms  out  1  JTAG TMS
- io_tdi  out  1  JTAG TDI
- io_tdo  in  1  JTAG TDO
- io_tapState  out  4  modelled TAP state

Behaviour:
- TAP encoding: F = Test-Logic-Reset, C = Run-Test/Idle, 7 = Select-DR, 6 = Capture-DR, 2 = Shift-DR, 1 = Exit1-DR, 3 = Pause-DR, 0 = Exit2-DR, 5 = Update-DR, 4 = Select-IR, E = Capture-IR, A = Shift-IR, 9 = Exit1-IR, B = Pause-IR, 8 = Exit2-IR, D = Update-IR.
- Reset values:
  - io_tck = 0, io_tms = 1, io_tdi = 0, io_tapState = F.
  - cmd_ready = 0, rsp_valid = 0, rsp_data = 0.
- TCK generation:
  - io_tck toggles every TCK_HALF clocks while a sequence runs and is held low otherwise.
  - TMS/TDI change only on the clock where io_tck goes 1->0, or at sequence start while TCK is low.
  - TDO is sampled, and io_tapState advances, on the clock where io_tck goes 0->1.
- Controller states: INIT, IDLE, RUN, RESP.
- INIT:
  - Entered on reset release.
  - Emits 5 TCK cycles with TMS = 1, then 1 cycle with TMS = 0; io_tapState ends at C.
  - cmd_ready stays low throughout.
- IDLE:
  - cmd_ready = 1 only here.
  - On accept: latches op, len and data; enters RUN on the next clock.
- RUN, DR scan of length L: TMS sequence is 1, 0, 0, then L shift cycles (TMS = 0 except the last, which is 1), then 1, 0. Total L + 5 TCK cycles.
- RUN, IR scan: TMS sequence is 1, 1, 0, 0, then shift as for DR, then 1, 0. Total L + 6 TCK cycles.
- RUN, TAP reset: 5 x TMS = 1 then TMS = 0; 6 TCK cycles.
- TDI and TDO:
  - TDI = data bit i during shift cycle i; TDI = 0 outside shift cycles.
  - TDO sampled in shift cycle i is written to rsp_data[i]; bits at index L and above read 0.
- Latency: rsp_valid rises exactly 2·TCK_HALF·N clocks after the accept clock, where N is the TCK cycle count. io_tck is low at that point.
- RESP: rsp_valid held until rsp_ready; return to IDLE on the next clock. Only one command is outstanding at a time.
- Boundary cases:
  - cmd_len = 0 on a scan: no TCK activity; rsp_valid asserts 1 clock after accept with rsp_data = 0.
  - cmd_len > MAX_LEN is clamped to MAX_LEN.
  - cmd_op = 3 behaves like len 0.
  - For TAP reset, rsp_data = 0.
- Reset mid-operation: all outputs return to reset values immediately; any command in flight is dropped with no response; INIT reruns on release.
- cmd_valid while not IDLE is ignored.
- cmd inputs must be stable only in the accept cycle.

Optional Feature:
- Macro: JTAG_SCAN_IDLE_CYCLES_EN.
- Defined:
  - Adds input cmd_idle[7:0], latched at accept.
  - After the final TMS = 0 of a scan or reset sequence, emits cmd_idle extra TCK cycles with TMS = 0, remaining in state C.
  - N grows by cmd_idle; the cmd_idle port is present.
- Undefined: port absent; zero extra cycles.

Test Plan:
- Reset release with TCK_HALF = 2 -> 6 TCK pulses with TMS 1,1,1,1,1,0; io_tapState = C; cmd_ready high at clock 24.
- DR scan, len = 8, data = 0xA5, TDO looped to TDI -> TDI sequence 1,0,1,0,0,1,0,1; rsp_data = 0xA5; rsp_valid 52 clocks after accept.
- IR scan, len = 5, data = 0x11, TDO tied 1 -> io_tapState passes F? no; passes 7,4,E,A..A,9,D,C; rsp_data = 0x1F; 11 TCK cycles.
- Scan with len = 0, then len = 100 with MAX_LEN = 64 -> first: immediate response with 0 and no TCK edges; second: 69 TCK cycles.
- rsp_ready held low for 10 clocks -> rsp_valid and rsp_data stable; cmd_ready stays 0 until the clock after the handshake.
- reset_n pulsed low mid-shift at bit 3 -> outputs at reset values in the same cycle; no rsp_valid; INIT reruns and the next command completes normally.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG master scan sequencer: walks the TAP through IR/DR scans and TAP resets, returns captured TDO.
// Optional feature macro JTAG_SCAN_IDLE_CYCLES_EN adds cmd_idle (extra Run-Test/Idle TCK cycles per command).
module jtag_scan_sequencer #(
    parameter int MAX_LEN  = 64,
    parameter int TCK_HALF = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_data,
`ifdef JTAG_SCAN_IDLE_CYCLES_EN
    input  logic [7:0]                   cmd_idle,
`endif
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [MAX_LEN-1:0]           rsp_data,
    output logic                         io_tck,
    output logic                         io_tms,
    output logic                         io_tdi,
    input  logic                         io_tdo,
    output logic [3:0]                   io_tapState
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(MAX_LEN + 262);
    localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_RST = 2'd2;

    localparam logic [3:0] TAP_TLR = 4'hF, TAP_RTI = 4'hC;
    localparam logic [3:0] TAP_SDR = 4'h7, TAP_CDR = 4'h6, TAP_SHD = 4'h2, TAP_E1D = 4'h1;
    localparam logic [3:0] TAP_PDR = 4'h3, TAP_E2D = 4'h0, TAP_UDR = 4'h5;
    localparam logic [3:0] TAP_SIR = 4'h4, TAP_CIR = 4'hE, TAP_SHI = 4'hA, TAP_E1I = 4'h9;
    localparam logic [3:0] TAP_PIR = 4'hB, TAP_E2I = 4'h8, TAP_UIR = 4'hD;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms_v);
        logic [3:0] n;
        case (s)
            TAP_TLR: n = tms_v ? TAP_TLR : TAP_RTI;
            TAP_RTI: n = tms_v ? TAP_SDR : TAP_RTI;
            TAP_SDR: n = tms_v ? TAP_SIR : TAP_CDR;
            TAP_CDR: n = tms_v ? TAP_E1D : TAP_SHD;
            TAP_SHD: n = tms_v ? TAP_E1D : TAP_SHD;
            TAP_E1D: n = tms_v ? TAP_UDR : TAP_PDR;
            TAP_PDR: n = tms_v ? TAP_E2D : TAP_PDR;
            TAP_E2D: n = tms_v ? TAP_UDR : TAP_SHD;
            TAP_UDR: n = tms_v ? TAP_SDR : TAP_RTI;
            TAP_SIR: n = tms_v ? TAP_TLR : TAP_CIR;
            TAP_CIR: n = tms_v ? TAP_E1I : TAP_SHI;
            TAP_SHI: n = tms_v ? TAP_E1I : TAP_SHI;
            TAP_E1I: n = tms_v ? TAP_UIR : TAP_PIR;
            TAP_PIR: n = tms_v ? TAP_E2I : TAP_PIR;
            TAP_E2I: n = tms_v ? TAP_UIR : TAP_SHI;
            TAP_UIR: n = tms_v ? TAP_SDR : TAP_RTI;
            default: n = TAP_TLR;
        endcase
        return n;
    endfunction

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [LW-1:0]      len_q;
    logic [7:0]         idle_q;
    logic               seq_on;
    logic [HW-1:0]      hcnt;
    logic [CW-1:0]      cyc;
    logic               tck, tms, tdi;
    logic [3:0]         tap;
    logic [MAX_LEN-1:0] tdi_sr;
    logic [MAX_LEN-1:0] bit_ptr;
    logic [MAX_LEN-1:0] rsp_q;

    logic [7:0]         idle_in;
    logic [LW-1:0]      len_clamp;
    logic               start_seq;
    logic [CW-1:0]      pre, shift_end, last_cyc, nxt;
    logic               cur_shift, nxt_shift, nxt_tms;
    logic               half_tick, seq_done;

`ifdef JTAG_SCAN_IDLE_CYCLES_EN
    assign idle_in = cmd_idle;
`else
    assign idle_in = 8'd0;
`endif

    assign len_clamp = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
    // Empty scans and the reserved op skip TCK entirely and respond straight from RUN.
    assign start_seq = (cmd_op == OP_RST) || (!cmd_op[1] && (cmd_len != '0));

    // Cycle map of a scan: [0, pre) walk to Shift, [pre, shift_end) shift, then Exit->Update->Idle, then idle.
    assign pre       = (op_q == OP_IR) ? CW'(4) : CW'(3);
    assign shift_end = pre + CW'(len_q);
    assign last_cyc  = ((op_q == OP_RST) ? CW'(5) : shift_end + CW'(1)) + CW'(idle_q);
    assign nxt       = cyc + CW'(1);
    assign cur_shift = (op_q != OP_RST) && (cyc >= pre) && (cyc < shift_end);
    assign nxt_shift = (op_q != OP_RST) && (nxt >= pre) && (nxt < shift_end);

    always_comb begin
        if (op_q == OP_RST)       nxt_tms = (nxt < CW'(5));
        else if (nxt < pre)       nxt_tms = (nxt < pre - CW'(2));
        else if (nxt < shift_end) nxt_tms = (nxt == shift_end - CW'(1));
        else                      nxt_tms = (nxt == shift_end);
    end

    assign half_tick = (hcnt == HALF_LAST);
    assign seq_done  = seq_on && half_tick && tck && (cyc == last_cyc);

    // NOTE: async reset in the sensitivity list plus <= everywhere keeps every flop race-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            op_q    <= OP_RST;
            len_q   <= '0;
            idle_q  <= '0;
            seq_on  <= 1'b1;
            hcnt    <= '0;
            cyc     <= '0;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            tap     <= TAP_TLR;
            tdi_sr  <= '0;
            bit_ptr <= '0;
            rsp_q   <= '0;
        end else begin
            case (state)
                ST_INIT: if (seq_done) state <= ST_IDLE;
                ST_IDLE: if (cmd_valid) begin
                    state   <= ST_RUN;
                    op_q    <= cmd_op;
                    len_q   <= len_clamp;
                    idle_q  <= idle_in;
                    tdi_sr  <= cmd_data;
                    bit_ptr <= MAX_LEN'(1);
                    rsp_q   <= '0;
                    seq_on  <= start_seq;
                    hcnt    <= '0;
                    cyc     <= '0;
                    tms     <= 1'b1;
                    tdi     <= 1'b0;
                end
                ST_RUN:  if (!seq_on || seq_done) state <= ST_RESP;
                default: if (rsp_ready) state <= ST_IDLE;
            endcase

            if (seq_on) begin
                if (half_tick) begin
                    hcnt <= '0;
                    if (!tck) begin
                        tck <= 1'b1;
                        tap <= tap_next(tap, tms);
                        if (cur_shift) begin
                            if (io_tdo) rsp_q <= rsp_q | bit_ptr;
                            bit_ptr <= bit_ptr << 1;
                        end
                    end else begin
                        tck <= 1'b0;
                        if (cyc == last_cyc) begin
                            seq_on <= 1'b0;
                        end else begin
                            cyc <= nxt;
                            tms <= nxt_tms;
                            if (nxt_shift) begin
                                tdi    <= tdi_sr[0];
                                tdi_sr <= tdi_sr >> 1;
                            end else begin
                                tdi <= 1'b0;
                            end
                        end
                    end
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_data    = rsp_q;
    assign io_tck      = tck;
    assign io_tms      = tms;
    assign io_tdi      = tdi;
    assign io_tapState = tap;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer (MAX_LEN = 64, TCK_HALF = 2) with hand-computed expectations.
module tb_jtag_scan_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_len;
    logic [63:0] cmd_data;
    logic [7:0]  cmd_idle = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        io_tck, io_tms, io_tdi, io_tdo;
    logic [3:0]  io_tapState;
    logic [1:0]  tdo_mode = 2'd0;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int acc_cnt = 0;
    int rise_cnt = 0;
    int rise_base = 0;
    logic tck_prev = 1'b0;
    logic       tms_log [0:1023];
    logic       tdi_log [0:1023];
    logic [3:0] tap_log [0:1023];

    assign io_tdo = (tdo_mode == 2'd2) ? io_tdi : tdo_mode[0];

    jtag_scan_sequencer #(.MAX_LEN(64), .TCK_HALF(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_SCAN_IDLE_CYCLES_EN
        .cmd_idle(cmd_idle),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .io_tck(io_tck), .io_tms(io_tms), .io_tdi(io_tdi), .io_tdo(io_tdo),
        .io_tapState(io_tapState)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    // Log TMS/TDI and the post-edge TAP state for every TCK rising edge.
    always @(negedge clock) begin
        if (io_tck && !tck_prev) begin
            tms_log[rise_cnt % 1024] = io_tms;
            tdi_log[rise_cnt % 1024] = io_tdi;
            tap_log[rise_cnt % 1024] = io_tapState;
            rise_cnt = rise_cnt + 1;
        end
        tck_prev = io_tck;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tms_seq(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = tms_log[(base + i) % 1024];
        return v;
    endfunction

    function automatic logic [63:0] tdi_seq(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 64; i++) v[i] = tdi_log[(base + i) % 1024];
        return v;
    endfunction

    function automatic logic [63:0] tap_seq(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n && i < 16; i++) v[4*i +: 4] = tap_log[(base + i) % 1024];
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_tck"}, io_tck, 1'b0);
        check({tag, "_tms"}, io_tms, 1'b1);
        check({tag, "_tdi"}, io_tdi, 1'b0);
        check({tag, "_tap"}, io_tapState, 4'hF);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
    endtask

    // Release reset and wait for the INIT walk to finish; counts any stray response.
    task automatic release_and_init(input string tag);
        int n = 0;
        int rel;
        int stray = 0;
        @(negedge clock);
        reset_n = 1'b1;
        rel = cyc_cnt;
        rise_base = rise_cnt;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            if (rsp_valid) stray++;
            n++;
        end
        check({tag, "_ready_clock"}, cyc_cnt - rel, 24);
        check({tag, "_tck_cycles"}, rise_cnt - rise_base, 6);
        check({tag, "_tms_seq"}, tms_seq(rise_base, 6), 64'h1F);
        check({tag, "_tap_end"}, io_tapState, 4'hC);
        check({tag, "_no_rsp"}, stray, 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        while (!cmd_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("issue_ready", cmd_ready, 1'b1);
        @(negedge clock);
        acc_cnt   = cyc_cnt;
        rise_base = rise_cnt;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_len   = 7'h7F;
        cmd_data  = '1;
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        lat = cyc_cnt - acc_cnt;
        check("rsp_arrived", rsp_valid, 1'b1);
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        check("hs_cmd_ready_low", cmd_ready, 1'b0);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("hs_rsp_dropped", rsp_valid, 1'b0);
        check("hs_back_idle", cmd_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int n;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = 7'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        release_and_init("init");

        // DR scan, 8 bits of 0xA5, TDO looped back.
        tdo_mode = 2'd2;
        issue(2'd0, 7'd8, 64'hA5);
        wait_rsp(200, lat);
        check("dr8_latency", lat, 52);
        check("dr8_tck_cycles", rise_cnt - rise_base, 13);
        check("dr8_tms_seq", tms_seq(rise_base, 13), 64'hC01);
        check("dr8_tdi_seq", tdi_seq(rise_base, 13), 64'h528);
        check("dr8_rsp_data", rsp_data, 64'hA5);
        check("dr8_tck_low", io_tck, 1'b0);
        check("dr8_tap_end", io_tapState, 4'hC);
        take();

        // IR scan, 5 bits of 0x11, TDO tied high.
        tdo_mode = 2'd1;
        issue(2'd1, 7'd5, 64'h11);
        wait_rsp(200, lat);
        check("ir5_latency", lat, 44);
        check("ir5_tck_cycles", rise_cnt - rise_base, 11);
        check("ir5_tms_seq", tms_seq(rise_base, 11), 64'h303);
        check("ir5_tdi_seq", tdi_seq(rise_base, 11), 64'h110);
        check("ir5_tap_seq", tap_seq(rise_base, 11), 64'hCD9AAAAAE47);
        check("ir5_rsp_data", rsp_data, 64'h1F);
        take();

        // Zero-length scan and reserved op: one-clock response, no TCK.
        issue(2'd0, 7'd0, 64'hFF);
        wait_rsp(20, lat);
        check("len0_latency", lat, 1);
        check("len0_tck_cycles", rise_cnt - rise_base, 0);
        check("len0_rsp_data", rsp_data, 64'd0);
        take();
        issue(2'd3, 7'd5, 64'hFF);
        wait_rsp(20, lat);
        check("op3_latency", lat, 1);
        check("op3_tck_cycles", rise_cnt - rise_base, 0);
        check("op3_rsp_data", rsp_data, 64'd0);
        take();

        // TAP reset command: six TCK cycles, zero response data.
        issue(2'd2, 7'd9, 64'hFFFF);
        wait_rsp(100, lat);
        check("rst_latency", lat, 24);
        check("rst_tms_seq", tms_seq(rise_base, 6), 64'h1F);
        check("rst_rsp_data", rsp_data, 64'd0);
        take();

        // Over-long scan is clamped to 64 bits; response then held for 10 clocks.
        tdo_mode = 2'd2;
        issue(2'd0, 7'd100, 64'hDEAD_BEEF_0123_4567);
        wait_rsp(400, lat);
        check("len100_latency", lat, 276);
        check("len100_tck_cycles", rise_cnt - rise_base, 69);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_data", rsp_data, 64'hDEAD_BEEF_0123_4567);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        take();

        // Reset during shift bit 3 of a DR scan, then a clean follow-up scan.
        issue(2'd0, 7'd8, 64'h3C);
        n = 0;
        while ((rise_cnt - rise_base) < 7 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("mid_reached_bit3", rise_cnt - rise_base, 7);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid");
        repeat (2) @(negedge clock);
        release_and_init("reinit");
        issue(2'd0, 7'd4, 64'h9);
        wait_rsp(200, lat);
        check("post_latency", lat, 36);
        check("post_rsp_data", rsp_data, 64'h9);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
